fp_seq_divider: RTL and testbench

//   Multi-cycle IEEE 754 single-precision divider (out = a / b) using restoring mantissa division.
//   It is the inverse-direction companion to the combinational multiplier datapath.
//   It replaces the reciprocal+multiply divide path where exact truncated quotients are needed.

---
 rtl/fp_seq_divider.sv | 202 ++++++++++++++++++++
 tb/tb_fp_seq_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_seq_divider.sv
// Multi-cycle IEEE 754 single-precision divider built on restoring mantissa division.
// Quotients are truncated toward zero, and denormal operands are treated as zero.
module fp_seq_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic          sign_r;
    logic [9:0]    exp_r;
    logic [25:0]   rem_r, rem_s;
    logic [23:0]   dvs_r;
    logic [24:0]   quo_r, quo_s;
    logic [4:0]    cnt_r;
    logic [31:0]   out_r, spec_out_s;
    logic [3:0]    flags_r, spec_flags_s;
    logic          spec_s, accept_s, sign_s;
    logic signed [9:0] fexp_s;
    logic [22:0]   mant_s;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    assign accept_s  = in_valid && (state_r == IDLE);
    assign sign_s    = a[31] ^ b[31];
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign out       = out_r;
    assign out_flags = flags_r;

    // Special-operand decode, evaluated in priority order on the live inputs
    always_comb begin
        spec_s       = 1'b1;
        spec_out_s   = 32'd0;
        spec_flags_s = 4'b0000;
        if (is_nan(a)) begin
            spec_out_s = {a[31], 8'hFF, 1'b1, a[21:0]};
        end else if (is_nan(b)) begin
            spec_out_s = {b[31], 8'hFF, 1'b1, b[21:0]};
        end else if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) begin
            spec_out_s   = 32'h7FC0_0000;
            spec_flags_s = 4'b1000;
        end else if (is_inf(a)) begin
            spec_out_s = {sign_s, 8'hFF, 23'd0};
        end else if (is_zero(b)) begin
            spec_out_s   = {sign_s, 8'hFF, 23'd0};
            spec_flags_s = 4'b0100;
        end else if (is_zero(a) || is_inf(b)) begin
            spec_out_s = {sign_s, 31'd0};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Restoring division step, unrolled BITS_PER_CYCLE times
    always_comb begin
        rem_s = rem_r;
        quo_s = quo_r;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_s >= {2'b00, dvs_r}) begin
                quo_s = {quo_s[23:0], 1'b1};
                rem_s = (rem_s - {2'b00, dvs_r}) << 1;
            end else begin
                quo_s = {quo_s[23:0], 1'b0};
                rem_s = rem_s << 1;
            end
        end
    end

    // Normalisation: quotient lies in [0.5, 2), so at most one left shift
    always_comb begin
        if (quo_r[24]) begin
            fexp_s = $signed(exp_r);
            mant_s = quo_r[23:1];
        end else begin
            fexp_s = $signed(exp_r - 10'd1);
            mant_s = quo_r[22:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = spec_s ? DONE : DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r <= 5'(BITS_PER_CYCLE)) begin
                    state_s = NORM;
                end else begin
                    state_s = DIV;
                end
            end
            NORM: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r  <= 1'b0;
            exp_r   <= 10'd0;
            rem_r   <= 26'd0;
            dvs_r   <= 24'd0;
            quo_r   <= 25'd0;
            cnt_r   <= 5'd0;
            out_r   <= 32'd0;
            flags_r <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_r <= sign_s;
                        exp_r  <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                        rem_r  <= {3'b001, a[22:0]};
                        dvs_r  <= {1'b1, b[22:0]};
                        quo_r  <= 25'd0;
                        cnt_r  <= 5'd25;
                        if (spec_s) begin
                            out_r   <= spec_out_s;
                            flags_r <= spec_flags_s;
                        end
                    end
                end
                DIV: begin
                    rem_r <= rem_s;
                    quo_r <= quo_s;
                    cnt_r <= cnt_r - 5'(BITS_PER_CYCLE);
                end
                NORM: begin
                    if (fexp_s >= 10'sd255) begin
                        out_r   <= {sign_r, 8'hFF, 23'd0};
                        flags_r <= 4'b0010;
                    end else if (fexp_s <= 10'sd0) begin
                        out_r   <= {sign_r, 31'd0};
                        flags_r <= 4'b0001;
                    end else begin
                        out_r   <= {sign_r, fexp_s[7:0], mant_s};
                        flags_r <= 4'b0000;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        flags_r <= 4'b0000;
                    end
                end
                default: begin
                    flags_r <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_seq_divider.sv
// Self-checking bench for fp_seq_divider: directed cases, handshake corners and
// random operands compared against an arithmetic reference model.
module tb_fp_seq_divider;

    localparam int BPC = 1;
    localparam int LAT_NORMAL = 25 / BPC + 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  out_flags;

    int n_cmp;
    int n_err;

    fp_seq_divider #(.BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: quotient value from integer division of the significands
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] o, output logic [3:0] f, output int lat);
        int   ex, ey, e;
        logic s, xn, yn, xi, yi, xz, yz;
        longint mx, my, q;
        logic [31:0] m;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xz = (ex == 0);
        yz = (ey == 0);
        f = 4'b0000;
        lat = 1;
        o = 32'd0;
        if (xn) o = {x[31], 8'hFF, 1'b1, x[21:0]};
        else if (yn) o = {y[31], 8'hFF, 1'b1, y[21:0]};
        else if ((xz && yz) || (xi && yi)) begin o = 32'h7FC0_0000; f = 4'b1000; end
        else if (xi) o = {s, 8'hFF, 23'd0};
        else if (yz) begin o = {s, 8'hFF, 23'd0}; f = 4'b0100; end
        else if (xz || yi) o = {s, 31'd0};
        else begin
            lat = LAT_NORMAL;
            mx = longint'({1'b1, x[22:0]});
            my = longint'({1'b1, y[22:0]});
            q  = (mx * 64'd16777216) / my;
            e  = ex - ey + 127;
            if (q >= 64'd16777216) m = 32'(q / 2) & 32'h007F_FFFF;
            else begin m = 32'(q) & 32'h007F_FFFF; e = e - 1; end
            if (e >= 255) begin o = {s, 8'hFF, 23'd0}; f = 4'b0010; end
            else if (e <= 0) begin o = {s, 31'd0}; f = 4'b0001; end
            else o = {s, 8'(e), m[22:0]};
        end
    endfunction

    // Issue one operation with out_ready high and check result, latency and release
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_);
        logic [31:0] eo;
        logic [3:0]  ef;
        int el, cyc;
        model(ta, tb_, eo, ef, el);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(el));
        chk("out", out, eo);
        chk("flags", 32'(out_flags), 32'(ef));
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("released_valid", 32'(out_valid), 32'd0);
        chk("released_flags", 32'(out_flags), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        int sel;
        sel = int'($urandom_range(0, 15));
        m = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) m = 23'd0;
        end else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, m};
    endfunction

    initial begin
        logic [31:0] hold_out;
        logic [3:0]  hold_flags;
        int cyc, seen;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);

        run_op(32'h40C0_0000, 32'h4000_0000);
        run_op(32'h3F80_0000, 32'h4040_0000);
        run_op(32'h3F80_0000, 32'h0000_0000);
        run_op(32'h0000_0000, 32'h0000_0000);
        run_op(32'hBF80_0000, 32'h7F80_0000);
        run_op(32'h7F00_0000, 32'h0080_0000);
        run_op(32'h0080_0000, 32'h7F00_0000);
        run_op(32'h7FA0_0001, 32'h7FC0_0002);
        run_op(32'h3F80_0000, 32'hFF90_0003);
        run_op(32'hFF80_0000, 32'h7F80_0000);
        run_op(32'hFF80_0000, 32'h0000_0000);

        // Backpressure
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("bp_latency", 32'(cyc), 32'(LAT_NORMAL));
        hold_out = out; hold_flags = out_flags;
        chk("bp_out", out, 32'h4040_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_out", out, hold_out);
            chk("bp_hold_flags", 32'(out_flags), 32'(hold_flags));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide
        a = 32'h3F80_0000; b = 32'h4040_0000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        // Back-to-back: second request waits with in_valid high
        a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h0000_0000; b = 32'h0000_0000;
        cyc = 1;
        while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b2b_first_out", out, 32'h4040_0000);
        @(negedge clk);
        chk("b2b_ready_after_hs", 32'(in_ready), 32'd1);
        chk("b2b_valid_after_hs", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        chk("b2b_second_out", out, 32'h7FC0_0000);
        chk("b2b_second_flags", 32'(out_flags), 32'h8);

        // Random operands
        for (int i = 0; i < 60; i++) begin
            run_op(rand_fp(), rand_fp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
